// File: rtl/uart_frame_pkg.sv
// Shared types, constants and the bytewise CRC helper for the UART frame receiver.
package uart_frame_pkg;

  typedef enum logic [1:0] {HUNT, PAYLOAD, CSUM_HI, CSUM_LO} frame_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  localparam int CSUM_SUM16 = 0;
  localparam int CSUM_CRC16 = 1;

  // CRC-16/CCITT-FALSE advanced by one whole byte, MSB first, unreflected.
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc,
                                                   input logic [7:0]  d);
    logic [15:0] c;
    c = crc ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    return c;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Oversampled UART byte receiver: 2-FF synchroniser, mid-bit sampling, stop check.
module uart_rx_byte
  import uart_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       framing_err_o
);

  localparam int          HALF      = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
  localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);

  logic [1:0]  sync;
  logic        rx_s, rx_prev;
  rx_state_e   state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shreg, sh_n;
  logic        bv_n, fe_n;

  assign rx_s   = sync[1];
  assign byte_o = shreg;

  // Synchroniser, edge history and receiver state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync          <= 2'b11;
      rx_prev       <= 1'b1;
      state         <= RX_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      byte_valid_o  <= 1'b0;
      framing_err_o <= 1'b0;
    end else begin
      sync          <= {sync[0], rxd};
      rx_prev       <= rx_s;
      state         <= state_n;
      cnt           <= cnt_n;
      bit_idx       <= bit_n;
      shreg         <= sh_n;
      byte_valid_o  <= bv_n;
      framing_err_o <= fe_n;
    end
  end

  // Bit timing: half-bit to the start centre, then one full bit per sample.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    bit_n   = bit_idx;
    sh_n    = shreg;
    bv_n    = 1'b0;
    fe_n    = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_s) state_n = RX_START;
      end
      RX_START: if (cnt == HALF_LAST) begin
        cnt_n   = '0;
        bit_n   = '0;
        state_n = rx_s ? RX_IDLE : RX_DATA;  // high again means a glitch
      end
      RX_DATA: if (cnt == FULL_LAST) begin
        cnt_n = '0;
        sh_n  = {rx_s, shreg[7:1]};          // LSB arrives first
        bit_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_n = RX_STOP;
      end
      RX_STOP: if (cnt == FULL_LAST) begin
        cnt_n = '0;
        if (rx_s) begin
          bv_n    = 1'b1;
          state_n = RX_IDLE;
        end else begin
          fe_n    = 1'b1;
          state_n = RX_WAIT_HIGH;            // don't re-trigger inside a break
        end
      end
      RX_WAIT_HIGH: begin
        cnt_n = '0;
        if (rx_s) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Command frame receiver: header hunt, payload capture, checksum check, stats.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          HDR_LEN      = 6,
  parameter logic [63:0] HEADER       = 64'h0000AA55EB901D1B,
  parameter int          PAYLOAD_LEN  = 8,
  parameter int          CSUM_MODE    = 0,
  parameter int          TIMEOUT_BITS = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rxd,
  output logic [PAYLOAD_LEN*8-1:0]   payload_o,
  output logic                       frame_valid_o,
  output logic                       csum_err_o,
  output logic                       framing_err_o,
  output logic                       timeout_o,
  output logic [15:0]                frame_cnt_o,
  output logic [15:0]                err_cnt_o,
  output logic                       busy_o
);

  localparam int          CAPW      = PAYLOAD_LEN * 8;
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  localparam logic [15:0] CSUM_INIT = (CSUM_MODE == CSUM_CRC16) ? CRC16_INIT : 16'h0000;

  // Header byte idx in transmit order (most significant used byte first).
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
    logic [63:0] s;
    s = HEADER >> (8 * (HDR_LEN - 1 - int'(idx)));
    return s[7:0];
  endfunction

  logic [7:0]   rx_byte;
  logic         rx_bv, rx_fe;

  frame_state_e state, state_n;
  logic [2:0]   k, k_n;
  logic [5:0]   pay_cnt, pc_n;
  logic [CAPW-1:0] cap, cap_n;
  logic [15:0]  csum, csum_n, csum_upd;
  logic [7:0]   csum_hi, hi_n;
  logic [31:0]  to_cnt;
  logic         busy, timeout_hit, good_n, cerr_n;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .byte_o        (rx_byte),
    .byte_valid_o  (rx_bv),
    .framing_err_o (rx_fe)
  );

  assign busy        = (state != HUNT) || (k != 3'd0);
  assign busy_o      = busy;
  assign timeout_hit = busy && !rx_bv && (to_cnt == TO_LAST);
  assign csum_upd    = (CSUM_MODE == CSUM_CRC16) ? crc16_ccitt_byte(csum, rx_byte)
                                                 : csum + {8'h00, rx_byte};

  // Frame state, capture and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HUNT;
      k             <= '0;
      pay_cnt       <= '0;
      cap           <= '0;
      csum          <= '0;
      csum_hi       <= '0;
      to_cnt        <= '0;
      payload_o     <= '0;
      frame_valid_o <= 1'b0;
      csum_err_o    <= 1'b0;
      framing_err_o <= 1'b0;
      timeout_o     <= 1'b0;
      frame_cnt_o   <= '0;
      err_cnt_o     <= '0;
    end else begin
      state         <= state_n;
      k             <= k_n;
      pay_cnt       <= pc_n;
      cap           <= cap_n;
      csum          <= csum_n;
      csum_hi       <= hi_n;
      to_cnt        <= (rx_bv || !busy || timeout_hit) ? 32'd0 : to_cnt + 32'd1;
      if (good_n) payload_o <= cap;
      frame_valid_o <= good_n;
      csum_err_o    <= cerr_n;
      framing_err_o <= rx_fe;
      timeout_o     <= timeout_hit;
      if (good_n) frame_cnt_o <= frame_cnt_o + 16'd1;
      // Coincident error events count once; the counter sticks at all-ones.
      if ((cerr_n || rx_fe || timeout_hit) && err_cnt_o != 16'hFFFF)
        err_cnt_o <= err_cnt_o + 16'd1;
    end
  end

  // Frame sequencing: aborts take priority, otherwise advance on each byte.
  always_comb begin
    state_n = state;
    k_n     = k;
    pc_n    = pay_cnt;
    cap_n   = cap;
    csum_n  = csum;
    hi_n    = csum_hi;
    good_n  = 1'b0;
    cerr_n  = 1'b0;
    if (timeout_hit || (rx_fe && busy)) begin
      state_n = HUNT;
      k_n     = '0;
    end else if (rx_bv) begin
      case (state)
        HUNT: begin
          if (rx_byte == hdr_byte(k)) begin
            if (k == 3'(HDR_LEN - 1)) begin
              state_n = PAYLOAD;
              k_n     = '0;
              pc_n    = '0;
              csum_n  = CSUM_INIT;
            end else begin
              k_n = k + 3'd1;
            end
          end else begin
            // A mismatching byte may itself start a new header.
            k_n = (rx_byte == hdr_byte(3'd0)) ? 3'd1 : 3'd0;
          end
        end
        PAYLOAD: begin
          cap_n  = CAPW'({cap, rx_byte});
          csum_n = csum_upd;
          pc_n   = pay_cnt + 6'd1;
          if (pay_cnt == 6'(PAYLOAD_LEN - 1)) state_n = CSUM_HI;
        end
        CSUM_HI: begin
          hi_n    = rx_byte;
          state_n = CSUM_LO;
        end
        CSUM_LO: begin
          if ({csum_hi, rx_byte} == csum) good_n = 1'b1;
          else                            cerr_n = 1'b1;
          state_n = HUNT;
          k_n     = '0;
        end
        default: state_n = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: sum16 instance plus a CRC16 / 9-byte instance.
module tb_uart_frame_rx;

  localparam int CPB = 16;
  localparam int BIT = CPB * 10;             // clock period is 10 time units

  localparam logic [127:0] HDR = 128'hAA55EB901D1B;
  localparam logic [127:0] P1  = 128'h0001000010000000;
  localparam logic [127:0] P2  = 128'h1122334455667788;
  localparam logic [127:0] P3  = 128'h313233343536373839;

  logic clk, rst, rst2, rxd1, rxd2;

  logic [63:0] payload1;
  logic        fv1_o, ce1_o, fe1_o, to1_o, busy1;
  logic [15:0] fcnt1, ecnt1;

  logic [71:0] payload2;
  logic        fv2_o, ce2_o, fe2_o, to2_o, busy2;
  logic [15:0] fcnt2, ecnt2;

  int checks = 0, failures = 0;
  int fv1 = 0, ce1 = 0, fe1 = 0, to1 = 0, fv2 = 0;
  int b_fv, b_ce, b_fe, b_to;

  uart_frame_rx #(.CLKS_PER_BIT(CPB)) dut1 (
    .clk(clk), .rst(rst), .rxd(rxd1),
    .payload_o(payload1), .frame_valid_o(fv1_o), .csum_err_o(ce1_o),
    .framing_err_o(fe1_o), .timeout_o(to1_o), .frame_cnt_o(fcnt1),
    .err_cnt_o(ecnt1), .busy_o(busy1)
  );

  uart_frame_rx #(.CLKS_PER_BIT(CPB), .PAYLOAD_LEN(9), .CSUM_MODE(1)) dut2 (
    .clk(clk), .rst(rst2), .rxd(rxd2),
    .payload_o(payload2), .frame_valid_o(fv2_o), .csum_err_o(ce2_o),
    .framing_err_o(fe2_o), .timeout_o(to2_o), .frame_cnt_o(fcnt2),
    .err_cnt_o(ecnt2), .busy_o(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies, sampled on the falling edge.
  always @(negedge clk) begin
    if (fv1_o) fv1++;
    if (ce1_o) ce1++;
    if (fe1_o) fe1++;
    if (to1_o) to1++;
    if (fv2_o) fv2++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input int line, input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (line == 1) rxd1 = fr[i]; else rxd2 = fr[i];
      #(BIT);
    end
    if (line == 1) rxd1 = 1'b1; else rxd2 = 1'b1;
  endtask

  // Send the low n bytes of v, most significant first.
  task automatic send_vec(input int line, input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(line, v[8*(n-1-i) +: 8], 1'b1);
  endtask

  task automatic mark();
    b_fv = fv1; b_ce = ce1; b_fe = fe1; b_to = to1;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; rxd1 = 1'b1; rxd2 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_payload", 128'(payload1), 128'h0);
    chk("rst_fv",      128'(fv1_o),    128'h0);
    chk("rst_ce",      128'(ce1_o),    128'h0);
    chk("rst_fe",      128'(fe1_o),    128'h0);
    chk("rst_to",      128'(to1_o),    128'h0);
    chk("rst_fcnt",    128'(fcnt1),    128'h0);
    chk("rst_ecnt",    128'(ecnt1),    128'h0);
    chk("rst_busy",    128'(busy1),    128'h0);
    rst = 1'b0; rst2 = 1'b0;
    #(2*BIT);

    // Good frame preceded by junk bytes.
    mark();
    send_vec(1, 128'h0102, 2);
    send_vec(1, HDR, 6);
    send_vec(1, P1, 8);
    send_vec(1, 128'h0011, 2);
    #(2*BIT);
    chk("s1_fv",      128'(fv1 - b_fv), 128'd1);
    chk("s1_payload", 128'(payload1),   P1);
    chk("s1_fcnt",    128'(fcnt1),      128'd1);
    chk("s1_errs",    128'((ce1 - b_ce) + (fe1 - b_fe) + (to1 - b_to)), 128'd0);
    chk("s1_ecnt",    128'(ecnt1),      128'd0);

    // Bad checksum.
    mark();
    send_vec(1, HDR, 6);
    send_vec(1, P1, 8);
    send_vec(1, 128'h0012, 2);
    #(2*BIT);
    chk("s2_ce",      128'(ce1 - b_ce), 128'd1);
    chk("s2_fv",      128'(fv1 - b_fv), 128'd0);
    chk("s2_payload", 128'(payload1),   P1);
    chk("s2_ecnt",    128'(ecnt1),      128'd1);
    chk("s2_fcnt",    128'(fcnt1),      128'd1);

    // Repeated first header byte.
    mark();
    send_byte(1, 8'hAA, 1'b1);
    send_vec(1, HDR, 6);
    send_vec(1, P1, 8);
    send_vec(1, 128'h0011, 2);
    #(2*BIT);
    chk("s3_fv",   128'(fv1 - b_fv), 128'd1);
    chk("s3_fcnt", 128'(fcnt1),      128'd2);

    // Inter-byte timeout after the third payload byte.
    mark();
    send_vec(1, HDR, 6);
    send_vec(1, 128'h000100, 3);
    chk("s4_busy_mid", 128'(busy1), 128'd1);
    #(30*BIT);
    chk("s4_to",       128'(to1 - b_to), 128'd1);
    chk("s4_ecnt",     128'(ecnt1),      128'd2);
    chk("s4_busy_end", 128'(busy1),      128'd0);
    mark();
    send_vec(1, HDR, 6);
    send_vec(1, P2, 8);
    send_vec(1, 128'h0264, 2);
    #(2*BIT);
    chk("s4_fv",      128'(fv1 - b_fv), 128'd1);
    chk("s4_payload", 128'(payload1),   P2);
    chk("s4_fcnt",    128'(fcnt1),      128'd3);

    // Low stop bit on the fifth payload byte.
    mark();
    send_vec(1, HDR, 6);
    send_vec(1, 128'h00010000, 4);
    send_byte(1, 8'h10, 1'b0);
    #(3*BIT);
    chk("s5_fe",   128'(fe1 - b_fe), 128'd1);
    chk("s5_busy", 128'(busy1),      128'd0);
    chk("s5_ecnt", 128'(ecnt1),      128'd3);
    chk("s5_nofv", 128'(fv1 - b_fv), 128'd0);
    mark();
    send_vec(1, HDR, 6);
    send_vec(1, P1, 8);
    send_vec(1, 128'h0011, 2);
    #(2*BIT);
    chk("s5_fv",      128'(fv1 - b_fv), 128'd1);
    chk("s5_payload", 128'(payload1),   P1);
    chk("s5_fcnt",    128'(fcnt1),      128'd4);

    // CRC16 instance: "123456789" has CRC 0x29B1.
    send_vec(2, HDR, 6);
    send_vec(2, P3, 9);
    send_vec(2, 128'h29B1, 2);
    #(2*BIT);
    chk("c1_fv",      128'(fv2),      128'd1);
    chk("c1_payload", 128'(payload2), P3);
    chk("c1_fcnt",    128'(fcnt2),    128'd1);
    chk("c1_ecnt",    128'(ecnt2),    128'd0);

    // Reset in the middle of a payload.
    send_vec(2, HDR, 6);
    send_vec(2, 128'h313233, 3);
    chk("c2_busy_mid", 128'(busy2), 128'd1);
    rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("c2_rst_payload", 128'(payload2), 128'h0);
    chk("c2_rst_fcnt",    128'(fcnt2),    128'h0);
    chk("c2_rst_ecnt",    128'(ecnt2),    128'h0);
    chk("c2_rst_busy",    128'(busy2),    128'h0);
    chk("c2_rst_pulses",  128'({fv2_o, ce2_o, fe2_o, to2_o}), 128'h0);
    rst2 = 1'b0;
    #(2*BIT);
    send_vec(2, HDR, 6);
    send_vec(2, P3, 9);
    send_vec(2, 128'h29B1, 2);
    #(2*BIT);
    chk("c3_fv",      128'(fv2),      128'd2);
    chk("c3_payload", 128'(payload2), P3);
    chk("c3_fcnt",    128'(fcnt2),    128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
